// File: rtl/multiplicador_seq8.sv
// Sequential shift-and-add 8x8 multiplier: one ripple-carry adder reused over eight cycles.
// Optional macro MULT_SIGNED_EN enables two's-complement operands via sign/magnitude handling.

module RippleCarryAdder8 (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cin_i,
  output logic [7:0] sum_o,
  output logic       cout_o
);

  logic [8:0] carry;

  always_comb begin
    carry    = '0;
    sum_o    = '0;
    carry[0] = cin_i;
    for (int i = 0; i < 8; i++) begin
      sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign cout_o = carry[8];

endmodule

module multiplicador_seq8 #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [7:0]       mcand_q;
  logic [15:0]      acc_q;
  logic [3:0]       cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [15:0]      p_q;

  logic [7:0]       addB;
  logic [7:0]       addSum;
  logic             addCout;
  logic [15:0]      acc_d;
  logic [7:0]       mcandLoad;
  logic [7:0]       mplierLoad;
  logic [15:0]      pFinal;

  // Partial product add: high half of acc plus the multiplicand when the current multiplier bit is set.
  assign addB = acc_q[0] ? mcand_q : 8'h00;

  RippleCarryAdder8 uAdder (
    .a_i    (acc_q[15:8]),
    .b_i    (addB),
    .cin_i  (1'b0),
    .sum_o  (addSum),
    .cout_o (addCout)
  );

  assign acc_d = {addCout, addSum, acc_q[7:1]};

`ifdef MULT_SIGNED_EN
  logic sign_q;
  logic signLoad;

  // Magnitudes fit in 8 unsigned bits, including -128 which maps to 8'h80.
  assign mcandLoad  = a[7] ? (~a + 8'd1) : a;
  assign mplierLoad = b[7] ? (~b + 8'd1) : b;
  assign signLoad   = a[7] ^ b[7];
  assign pFinal     = sign_q ? (~acc_d + 16'd1) : acc_d;
`else
  assign mcandLoad  = a;
  assign mplierLoad = b;
  assign pFinal     = acc_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      p_q     <= '0;
`ifdef MULT_SIGNED_EN
      sign_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= CALC;
            busy_q  <= 1'b1;
            mcand_q <= mcandLoad;
            acc_q   <= {8'h00, mplierLoad};
            cnt_q   <= '0;
`ifdef MULT_SIGNED_EN
            sign_q  <= signLoad;
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            p_q     <= pFinal;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign p    = p_q;

endmodule

// File: tb/tb_multiplicador_seq8.sv
// Self-checking bench for multiplicador_seq8: vector table, handshake corner cases and random operands.
// Follows MULT_SIGNED_EN so the reference model matches the build.

module tb_multiplicador_seq8;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] expP;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] p;

  int checks;
  int failures;

  vec_t vecs [5];

  multiplicador_seq8 #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference product straight from arithmetic, no shift-and-add.
  function automatic logic [15:0] refMul(input logic [7:0] av, input logic [7:0] bv);
    logic signed [15:0] sa;
    logic signed [15:0] sb;
    logic signed [15:0] sp;
`ifdef MULT_SIGNED_EN
    sa = {{8{av[7]}}, av};
    sb = {{8{bv[7]}}, bv};
`else
    sa = {8'h00, av};
    sb = {8'h00, bv};
`endif
    sp = sa * sb;
    return sp;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, actual, expected);
    end
  endtask

  // Launches one operation at the next rising edge; start drops right after that edge.
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv);
    @(negedge clk);
    start = 1'b1;
    a     = av;
    b     = bv;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
  endtask

  // Counts negedges after the accepting edge until done; a missing done yields a latency of 20.
  task automatic waitDone(output int latency, output int busyCycles);
    latency    = 20;
    busyCycles = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        latency = i;
        break;
      end
      if (busy) busyCycles++;
    end
  endtask

  task automatic runMult(input string name, input logic [7:0] av, input logic [7:0] bv, input logic [15:0] expP);
    int lat;
    int bc;
    applyStimulus(av, bv);
    waitDone(lat, bc);
    checkOutput({name, " latency"}, 16'(lat), 16'd8);
    checkOutput({name, " busy cycles"}, 16'(bc), 16'd8);
    checkOutput({name, " busy at done"}, {15'd0, busy}, 16'd0);
    checkOutput({name, " p"}, p, expP);
    @(negedge clk);
    checkOutput({name, " done one cycle"}, {15'd0, done}, 16'd0);
    checkOutput({name, " p held"}, p, expP);
  endtask

  initial begin
    int lat;
    int bc;
    logic [7:0] ra;
    logic [7:0] rb;

    checks   = 0;
    failures = 0;

`ifdef MULT_SIGNED_EN
    vecs[0] = '{a: 8'd13, b: 8'd11, expP: 16'h008F};
    vecs[1] = '{a: 8'hFF, b: 8'h02, expP: 16'hFFFE};
    vecs[2] = '{a: 8'h80, b: 8'h80, expP: 16'h4000};
    vecs[3] = '{a: 8'h80, b: 8'h01, expP: 16'hFF80};
    vecs[4] = '{a: 8'h00, b: 8'h5A, expP: 16'h0000};
`else
    vecs[0] = '{a: 8'd13, b: 8'd11, expP: 16'h008F};
    vecs[1] = '{a: 8'hFF, b: 8'hFF, expP: 16'hFE01};
    vecs[2] = '{a: 8'h00, b: 8'h5A, expP: 16'h0000};
    vecs[3] = '{a: 8'h01, b: 8'hFF, expP: 16'h00FF};
    vecs[4] = '{a: 8'h80, b: 8'h02, expP: 16'h0100};
`endif

    rst_n = 1'b0;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", {15'd0, busy}, 16'd0);
    checkOutput("reset done", {15'd0, done}, 16'd0);
    checkOutput("reset p", p, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      runMult($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].expP);
    end

    // Start pulse during CALC must be ignored.
    applyStimulus(8'h10, 8'h10);
    repeat (3) @(negedge clk);
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    waitDone(lat, bc);
    checkOutput("ignored start latency", 16'(lat + 4), 16'd8);
    checkOutput("ignored start p", p, 16'h0100);
    @(negedge clk);
    checkOutput("ignored start no restart", {15'd0, busy}, 16'd0);

    // Asynchronous abort mid-CALC.
    applyStimulus(8'h20, 8'h03);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort busy", {15'd0, busy}, 16'd0);
    checkOutput("abort p", p, 16'h0000);
    checkOutput("abort done", {15'd0, done}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) bc++;
    end
    checkOutput("post abort idle", 16'(bc), 16'd0);
    checkOutput("post abort p", p, 16'h0000);
    runMult("after abort", 8'd2, 8'd3, 16'h0006);

    // Start held high: back-to-back with fresh operands.
    @(negedge clk);
    start = 1'b1;
    a     = 8'd3;
    b     = 8'd4;
    @(posedge clk);
    #1;
    a     = 8'd5;
    b     = 8'd6;
    waitDone(lat, bc);
    checkOutput("b2b first latency", 16'(lat), 16'd8);
    checkOutput("b2b first p", p, 16'h000C);
    waitDone(lat, bc);
    checkOutput("b2b spacing", 16'(lat + 1), 16'd9);
    checkOutput("b2b second p", p, 16'h001E);
    start = 1'b0;
    @(negedge clk);
    checkOutput("b2b settle", {15'd0, done | busy}, 16'd0);

    // Random operands against the arithmetic reference.
    for (int i = 0; i < 16; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      applyStimulus(ra, rb);
      waitDone(lat, bc);
      checkOutput($sformatf("rand%0d latency", i), 16'(lat), 16'd8);
      checkOutput($sformatf("rand%0d p %02h*%02h", i, ra, rb), p, refMul(ra, rb));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
